// File: rtl/geo_seq_pkg.sv
// Shared types and constants for the geo_line_sequencer shape front end.
// Holds the shape opcode and FSM state encodings plus the per-shape
// segment count used to find the last segment of a shape.
package geo_seq_pkg;

    localparam int DEFAULT_COORD_W = 12;

    typedef enum logic [1:0] {
        OP_LINE = 2'd0,
        OP_POLY = 2'd1,
        OP_TRI  = 2'd2,
        OP_BOX  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Number of line segments a shape is broken into.
    function automatic logic [2:0] seg_count(input op_t op);
        logic [2:0] n;
        case (op)
            OP_LINE: n = 3'd1;
            OP_POLY: n = 3'd1;
            OP_TRI:  n = 3'd3;
            OP_BOX:  n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/geo_seq_vertex_mux.sv
// Segment endpoint selector for geo_line_sequencer.
// Maps (shape op, segment index, latched vertices, previous end point)
// to the start/end coordinates of that segment. Purely combinational;
// the parent registers the result when it launches a segment.
module geo_seq_vertex_mux
    import geo_seq_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
) (
    input  op_t                        op,
    input  logic [1:0]                 seg_idx,
    input  logic signed [COORD_W-1:0]  x0,
    input  logic signed [COORD_W-1:0]  y0,
    input  logic signed [COORD_W-1:0]  x1,
    input  logic signed [COORD_W-1:0]  y1,
    input  logic signed [COORD_W-1:0]  x2,
    input  logic signed [COORD_W-1:0]  y2,
    input  logic signed [COORD_W-1:0]  last_x,
    input  logic signed [COORD_W-1:0]  last_y,
    output logic signed [COORD_W-1:0]  ax,
    output logic signed [COORD_W-1:0]  ay,
    output logic signed [COORD_W-1:0]  bx,
    output logic signed [COORD_W-1:0]  by
);

    // Segment table: LINE and POLY are single segments, TRI walks
    // v0->v1->v2->v0 and BOX walks the four corners clockwise from v0.
    always_comb begin
        ax = x0;
        ay = y0;
        bx = x1;
        by = y1;
        case (op)
            OP_LINE: begin
                ax = x0;
                ay = y0;
                bx = x1;
                by = y1;
            end
            OP_POLY: begin
                ax = last_x;
                ay = last_y;
                bx = x1;
                by = y1;
            end
            OP_TRI: begin
                case (seg_idx)
                    2'd0: begin
                        ax = x0; ay = y0; bx = x1; by = y1;
                    end
                    2'd1: begin
                        ax = x1; ay = y1; bx = x2; by = y2;
                    end
                    default: begin
                        ax = x2; ay = y2; bx = x0; by = y0;
                    end
                endcase
            end
            OP_BOX: begin
                case (seg_idx)
                    2'd0: begin
                        ax = x0; ay = y0; bx = x1; by = y0;
                    end
                    2'd1: begin
                        ax = x1; ay = y0; bx = x1; by = y1;
                    end
                    2'd2: begin
                        ax = x1; ay = y1; bx = x0; by = y1;
                    end
                    default: begin
                        ax = x0; ay = y1; bx = x0; by = y0;
                    end
                endcase
            end
            default: begin
                ax = x0; ay = y0; bx = x1; by = y1;
            end
        endcase
    end

endmodule

// File: rtl/geo_line_sequencer.sv
// Shape-command front end for one line_generator in the Geo_Writer pipeline.
// Accepts LINE / POLY / TRI / BOX commands, splits each into segments and
// issues them one at a time, waiting for the generator's completion pulse.
// Optional feature macro: GEO_SEQ_ABORT_EN adds an abort input that drops the
// current shape and pulses lg_abort_rst towards the line generator.
module geo_line_sequencer
    import geo_seq_pkg::*;
#(
    parameter int COORD_W    = DEFAULT_COORD_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic signed [COORD_W-1:0]  cmd_x0,
    input  logic signed [COORD_W-1:0]  cmd_y0,
    input  logic signed [COORD_W-1:0]  cmd_x1,
    input  logic signed [COORD_W-1:0]  cmd_y1,
    input  logic signed [COORD_W-1:0]  cmd_x2,
    input  logic signed [COORD_W-1:0]  cmd_y2,
    input  logic                       pix_ready,
    output logic                       lg_enable,
    output logic                       lg_run,
    output logic signed [COORD_W-1:0]  lg_ax,
    output logic signed [COORD_W-1:0]  lg_ay,
    output logic signed [COORD_W-1:0]  lg_bx,
    output logic signed [COORD_W-1:0]  lg_by,
    output logic                       lg_ena_pause,
    input  logic                       lg_line_complete,
`ifdef GEO_SEQ_ABORT_EN
    input  logic                       abort,
    output logic                       lg_abort_rst,
`endif
    output logic                       seq_busy,
    output logic                       shape_done
);

    // GAP lasts GAP_CYCLES+1 cycles: the counter runs 0..GAP_LAST inclusive.
    localparam logic [3:0] GAP_LAST = GAP_CYCLES[3:0];

    state_t                      state;
    op_t                         op_q;
    logic [1:0]                  seg_idx;
    logic [3:0]                  gap_cnt;
    logic signed [COORD_W-1:0]   x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic signed [COORD_W-1:0]   last_x, last_y;

    op_t                         mux_op;
    logic [1:0]                  mux_idx;
    logic signed [COORD_W-1:0]   mux_x0, mux_y0, mux_x1, mux_y1, mux_x2, mux_y2;
    logic signed [COORD_W-1:0]   seg_ax, seg_ay, seg_bx, seg_by;
    logic                        seg_is_last;

    assign lg_ena_pause = !pix_ready;
    assign seg_is_last  = ({1'b0, seg_idx} == (seg_count(op_q) - 3'd1));

    // In IDLE the first segment is built straight from the command bus so it
    // can be registered on the accepting edge; later segments use latched data.
    always_comb begin
        mux_op  = op_q;
        mux_idx = seg_idx;
        mux_x0  = x0_q;
        mux_y0  = y0_q;
        mux_x1  = x1_q;
        mux_y1  = y1_q;
        mux_x2  = x2_q;
        mux_y2  = y2_q;
        if (state == S_IDLE) begin
            mux_op  = op_t'(cmd_op);
            mux_idx = 2'd0;
            mux_x0  = cmd_x0;
            mux_y0  = cmd_y0;
            mux_x1  = cmd_x1;
            mux_y1  = cmd_y1;
            mux_x2  = cmd_x2;
            mux_y2  = cmd_y2;
        end
    end

    geo_seq_vertex_mux #(
        .COORD_W (COORD_W)
    ) u_vertex_mux (
        .op      (mux_op),
        .seg_idx (mux_idx),
        .x0      (mux_x0),
        .y0      (mux_y0),
        .x1      (mux_x1),
        .y1      (mux_y1),
        .x2      (mux_x2),
        .y2      (mux_y2),
        .last_x  (last_x),
        .last_y  (last_y),
        .ax      (seg_ax),
        .ay      (seg_ay),
        .bx      (seg_bx),
        .by      (seg_by)
    );

    // Sequencer FSM with registered handshake, strobe and coordinate outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_LINE;
            seg_idx    <= 2'd0;
            gap_cnt    <= 4'd0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            last_x     <= '0;
            last_y     <= '0;
            cmd_ready  <= 1'b1;
            lg_enable  <= 1'b0;
            lg_run     <= 1'b0;
            lg_ax      <= '0;
            lg_ay      <= '0;
            lg_bx      <= '0;
            lg_by      <= '0;
            seq_busy   <= 1'b0;
            shape_done <= 1'b0;
`ifdef GEO_SEQ_ABORT_EN
            lg_abort_rst <= 1'b0;
`endif
        end else begin
            lg_enable  <= 1'b1;
            lg_run     <= 1'b0;
            shape_done <= 1'b0;
`ifdef GEO_SEQ_ABORT_EN
            lg_abort_rst <= 1'b0;
            if (abort && (state == S_LAUNCH || state == S_WAIT || state == S_GAP)) begin
                state        <= S_IDLE;
                cmd_ready    <= 1'b1;
                seq_busy     <= 1'b0;
                lg_abort_rst <= 1'b1;
            end else
`endif
            begin
                case (state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            op_q      <= op_t'(cmd_op);
                            x0_q      <= cmd_x0;
                            y0_q      <= cmd_y0;
                            x1_q      <= cmd_x1;
                            y1_q      <= cmd_y1;
                            x2_q      <= cmd_x2;
                            y2_q      <= cmd_y2;
                            seg_idx   <= 2'd0;
                            lg_ax     <= seg_ax;
                            lg_ay     <= seg_ay;
                            lg_bx     <= seg_bx;
                            lg_by     <= seg_by;
                            lg_run    <= 1'b1;
                            cmd_ready <= 1'b0;
                            seq_busy  <= 1'b1;
                            state     <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lg_line_complete) begin
                            last_x <= lg_bx;
                            last_y <= lg_by;
                            if (seg_is_last) begin
                                shape_done <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                seg_idx <= seg_idx + 2'd1;
                                gap_cnt <= 4'd0;
                                state   <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            lg_ax  <= seg_ax;
                            lg_ay  <= seg_ay;
                            lg_bx  <= seg_bx;
                            lg_by  <= seg_by;
                            lg_run <= 1'b1;
                            state  <= S_LAUNCH;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    S_DONE: begin
                        cmd_ready <= 1'b1;
                        seq_busy  <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: begin
                        cmd_ready <= 1'b1;
                        seq_busy  <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_geo_line_sequencer.sv
// Directed self-checking bench for geo_line_sequencer (GAP_CYCLES = 3).
// The bench plays the role of the line generator by pulsing lg_line_complete.
module tb_geo_line_sequencer;

    localparam int CW  = 12;
    localparam int GAP = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic signed [CW-1:0]   cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2;
    logic                   pix_ready;
    logic                   lg_enable;
    logic                   lg_run;
    logic signed [CW-1:0]   lg_ax, lg_ay, lg_bx, lg_by;
    logic                   lg_ena_pause;
    logic                   lg_line_complete;
    logic                   seq_busy;
    logic                   shape_done;
`ifdef GEO_SEQ_ABORT_EN
    logic                   abort;
    logic                   lg_abort_rst;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int run_count   = 0;
    int done_count  = 0;

    geo_line_sequencer #(
        .COORD_W    (CW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_x0           (cmd_x0),
        .cmd_y0           (cmd_y0),
        .cmd_x1           (cmd_x1),
        .cmd_y1           (cmd_y1),
        .cmd_x2           (cmd_x2),
        .cmd_y2           (cmd_y2),
        .pix_ready        (pix_ready),
        .lg_enable        (lg_enable),
        .lg_run           (lg_run),
        .lg_ax            (lg_ax),
        .lg_ay            (lg_ay),
        .lg_bx            (lg_bx),
        .lg_by            (lg_by),
        .lg_ena_pause     (lg_ena_pause),
        .lg_line_complete (lg_line_complete),
`ifdef GEO_SEQ_ABORT_EN
        .abort            (abort),
        .lg_abort_rst     (lg_abort_rst),
`endif
        .seq_busy         (seq_busy),
        .shape_done       (shape_done)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (lg_run)     run_count++;
        if (shape_done) done_count++;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input int x0, input int y0,
                                 input int x1, input int y1, input int x2, input int y2);
        cmd_op    = op;
        cmd_x0    = CW'(x0);
        cmd_y0    = CW'(y0);
        cmd_x1    = CW'(x1);
        cmd_y1    = CW'(y1);
        cmd_x2    = CW'(x2);
        cmd_y2    = CW'(y2);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        checkOutput("accept_ready_low", cmd_ready, 0);
        checkOutput("accept_run_latency", lg_run, 1);
        checkOutput("accept_busy", seq_busy, 1);
    endtask

    task automatic waitRun(input string tag);
        int n = 0;
        while (!lg_run && n < 64) begin
            step();
            n++;
        end
        checkOutput({tag, "_gap_latency"}, n + 1, GAP + 2);
    endtask

    task automatic doSegment(input string tag, input int ax, input int ay,
                             input int bx, input int by, input bit first, input bit last);
        if (!first) waitRun(tag);
        checkOutput({tag, "_run"}, lg_run, 1);
        checkOutput({tag, "_ax"}, lg_ax, ax);
        checkOutput({tag, "_ay"}, lg_ay, ay);
        checkOutput({tag, "_bx"}, lg_bx, bx);
        checkOutput({tag, "_by"}, lg_by, by);
        step();
        checkOutput({tag, "_run_pulse"}, lg_run, 0);
        checkOutput({tag, "_hold_bx"}, lg_bx, bx);
        step();
        lg_line_complete = 1'b1;
        step();
        lg_line_complete = 1'b0;
        if (last) begin
            checkOutput({tag, "_done"}, shape_done, 1);
            checkOutput({tag, "_busy_at_done"}, seq_busy, 1);
            step();
            checkOutput({tag, "_done_pulse"}, shape_done, 0);
            checkOutput({tag, "_ready_again"}, cmd_ready, 1);
            checkOutput({tag, "_busy_clear"}, seq_busy, 0);
        end else begin
            checkOutput({tag, "_no_done"}, shape_done, 0);
        end
    endtask

    initial begin
        int r0, d0, pause_cnt, extra_runs;
        reset            = 1'b1;
        cmd_valid        = 1'b0;
        cmd_op           = 2'd0;
        cmd_x0           = '0;
        cmd_y0           = '0;
        cmd_x1           = '0;
        cmd_y1           = '0;
        cmd_x2           = '0;
        cmd_y2           = '0;
        pix_ready        = 1'b1;
        lg_line_complete = 1'b0;
`ifdef GEO_SEQ_ABORT_EN
        abort            = 1'b0;
`endif
        step();
        step();
        $display("[TB] reset state");
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_lg_run", lg_run, 0);
        checkOutput("rst_seq_busy", seq_busy, 0);
        checkOutput("rst_shape_done", shape_done, 0);
        checkOutput("rst_lg_ax", lg_ax, 0);
        checkOutput("rst_lg_by", lg_by, 0);
        reset = 1'b0;
        step();
        checkOutput("lg_enable", lg_enable, 1);

        $display("[TB] LINE (0,0)->(3,1)");
        r0 = run_count; d0 = done_count;
        applyStimulus(2'd0, 0, 0, 3, 1, 0, 0);
        doSegment("line", 0, 0, 3, 1, 1'b1, 1'b1);
        checkOutput("line_runs", run_count - r0, 1);
        checkOutput("line_dones", done_count - d0, 1);

        $display("[TB] stray completion in IDLE");
        lg_line_complete = 1'b1;
        step();
        lg_line_complete = 1'b0;
        step();
        checkOutput("idle_complete_done", shape_done, 0);
        checkOutput("idle_complete_ready", cmd_ready, 1);
        checkOutput("idle_complete_dones", done_count - d0, 1);

        $display("[TB] POLY continuation");
        applyStimulus(2'd1, 100, -100, 5, 5, 0, 0);
        doSegment("poly1", 3, 1, 5, 5, 1'b1, 1'b1);
        applyStimulus(2'd1, 77, 77, -2, 7, 0, 0);
        doSegment("poly2", 5, 5, -2, 7, 1'b1, 1'b1);

        $display("[TB] TRI with command bus changing while busy");
        r0 = run_count; d0 = done_count;
        applyStimulus(2'd2, 0, 0, 8, 0, 4, 6);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_x0    = -9;
        cmd_y0    = -9;
        cmd_x1    = 33;
        cmd_y1    = 44;
        cmd_x2    = 55;
        cmd_y2    = 66;
        doSegment("tri0", 0, 0, 8, 0, 1'b1, 1'b0);
        doSegment("tri1", 8, 0, 4, 6, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        doSegment("tri2", 4, 6, 0, 0, 1'b0, 1'b1);
        checkOutput("tri_runs", run_count - r0, 3);
        checkOutput("tri_dones", done_count - d0, 1);

        $display("[TB] BOX (10,10),(20,15)");
        r0 = run_count; d0 = done_count;
        applyStimulus(2'd3, 10, 10, 20, 15, 0, 0);
        doSegment("box0", 10, 10, 20, 10, 1'b1, 1'b0);
        doSegment("box1", 20, 10, 20, 15, 1'b0, 1'b0);
        doSegment("box2", 20, 15, 10, 15, 1'b0, 1'b0);
        doSegment("box3", 10, 15, 10, 10, 1'b0, 1'b1);
        checkOutput("box_runs", run_count - r0, 4);
        checkOutput("box_dones", done_count - d0, 1);

        $display("[TB] pixel back-pressure during WAIT");
        applyStimulus(2'd0, 1, 1, 2, 2, 0, 0);
        step();
        r0 = run_count; d0 = done_count;
        pix_ready = 1'b0;
        #1;
        checkOutput("pause_comb", lg_ena_pause, 1);
        pause_cnt  = 0;
        extra_runs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (lg_ena_pause) pause_cnt++;
            if (lg_run) extra_runs++;
        end
        pix_ready = 1'b1;
        #1;
        checkOutput("pause_cycles", pause_cnt, 20);
        checkOutput("pause_extra_runs", extra_runs + (run_count - r0), 0);
        checkOutput("pause_release", lg_ena_pause, 0);
        checkOutput("pause_busy", seq_busy, 1);
        checkOutput("pause_no_done", done_count - d0, 0);
        lg_line_complete = 1'b1;
        step();
        lg_line_complete = 1'b0;
        checkOutput("pause_done_after", shape_done, 1);
        step();

        $display("[TB] reset during BOX segment 2");
        applyStimulus(2'd3, 0, 0, 4, 4, 0, 0);
        doSegment("rbox0", 0, 0, 4, 0, 1'b1, 1'b0);
        waitRun("rbox1");
        checkOutput("rbox1_ax", lg_ax, 4);
        checkOutput("rbox1_by", lg_by, 4);
        step();
        r0 = run_count; d0 = done_count;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst_mid_ready", cmd_ready, 1);
        checkOutput("rst_mid_busy", seq_busy, 0);
        checkOutput("rst_mid_run", lg_run, 0);
        checkOutput("rst_mid_bx", lg_bx, 0);
        for (int i = 0; i < 8; i++) step();
        checkOutput("rst_mid_runs", run_count - r0, 0);
        checkOutput("rst_mid_dones", done_count - d0, 0);
        applyStimulus(2'd1, 9, 9, 1, 2, 0, 0);
        doSegment("rst_poly", 0, 0, 1, 2, 1'b1, 1'b1);

`ifdef GEO_SEQ_ABORT_EN
        $display("[TB] abort during BOX segment 2");
        applyStimulus(2'd3, 0, 0, 6, 6, 0, 0);
        doSegment("abox0", 0, 0, 6, 0, 1'b1, 1'b0);
        waitRun("abox1");
        step();
        d0 = done_count;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_rst_pulse", lg_abort_rst, 1);
        checkOutput("abort_ready", cmd_ready, 1);
        checkOutput("abort_no_done", shape_done, 0);
        step();
        checkOutput("abort_rst_clear", lg_abort_rst, 0);
        checkOutput("abort_dones", done_count - d0, 0);
        applyStimulus(2'd1, 0, 0, 3, 3, 0, 0);
        doSegment("abort_poly", 6, 0, 3, 3, 1'b1, 1'b1);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
